param_data_buffer: RTL and testbench
====================================

// Module: param_data_buffer
// PURPOSE
//  Parametrised circular byte FIFO between the USB packet side (byte-wide) and the AHB-Lite slave (word-wide).
//  Successor to the fixed 64-byte endpoint buffer: generic depth and bus width, registered read paths,
//  explicit full/empty flags and defined overflow/underflow handling. Sits between USB RX/TX and the AHB slave.
// PARAMETERS
//  DEPTH      64  buffer capacity in bytes; power of 2, >=8
//  BUS_BYTES  4   AHB word width in bytes (1,2,4); SIZE_W = $clog2(BUS_BYTES) (min 1), OCC_W = $clog2(DEPTH+1)
// PORTS
//  clk                   in   1             system clock, rising edge
//  rst                   in   1             reset: asynchronous, active-high
//  clear                 in   1             synchronous flush of buffer contents
//  store_rx_packet_data  in   1             push rx_packet_data (1 byte)
//  rx_packet_data        in   8             byte from USB RX
//  get_rx_data           in   1             pop data_size+1 bytes onto rx_data
//  data_size             in   SIZE_W        transfer size minus 1, shared by get_rx_data/store_tx_data
//  tx_data               in   8*BUS_BYTES   word from AHB slave
//  store_tx_data         in   1             push data_size+1 bytes of tx_data
//  get_tx_packet_data    in   1             pop 1 byte onto tx_packet_data
//  buffer_occupancy      out  OCC_W         bytes currently stored
//  buffer_full           out  1             occupancy == DEPTH
//  buffer_empty          out  1             occupancy == 0
//  rx_data               out  8*BUS_BYTES   registered word to AHB slave
//  tx_packet_data        out  8             registered byte to USB TX
// BEHAVIOUR
//  - Reset: pointers, occupancy, rx_data, tx_packet_data = 0; buffer_empty=1, buffer_full=0. Storage array not reset.
//  - Storage: DEPTH x 8 array, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy kept as a counter.
//  - Byte order little-endian: lane 0 (bits 7:0) is first in/out; unused upper lanes of rx_data driven 0.
//  - Priority each cycle: clear > writes/reads. clear: ptrs and occupancy -> 0; rx_data/tx_packet_data hold.
//  - Writes: store_tx_data beats store_rx_packet_data if both asserted; the losing byte is dropped.
//  - Reads: get_rx_data beats get_tx_packet_data if both asserted; the losing request is ignored.
//  - One write and one read may complete in the same cycle; the read sees only pre-edge contents;
//    occupancy_next = occupancy + n_wr - n_rd.
//  - Write of n bytes accepted only if DEPTH - occupancy >= n (pre-edge); else entire write dropped, no partial write.
//  - Read of n bytes accepted only if occupancy >= n (pre-edge); else no pointer move and output register holds.
//  - Latency: accepted read updates rx_data / tx_packet_data at the request edge; valid one cycle after the
//    request is sampled. Outputs hold until the next accepted read of the same kind.
//  - Requests are level-sampled: a strobe held high N cycles performs N transfers.
//  - Reset mid-operation: asynchronous, takes effect immediately; no transfer completes on the edge where rst=1.
//  - full/empty are combinational from the occupancy register.
// CONFIGURATION
//  - `define DATA_BUFFER_ERR_EN: adds outputs overflow_err and underflow_err (1 bit each, reset 0).
//    overflow_err is set sticky by any dropped write, including an arbitration loss.
//    underflow_err is set sticky by any rejected read for lack of data. Both are cleared only by clear or rst.
//  - Undefined: ports absent; drops and rejections remain silent. Datapath is identical in both builds.
// TESTING
//  1 rst, push bytes FF,C9,9A,3B, then get_rx_data with data_size=3 -> rx_data=32'h3B9AC9FF next cycle;
//    occupancy 4 -> 0; buffer_empty=1.
//  2 store_tx_data tx_data=32'h00002B67, data_size=1 -> occupancy=2; two get_tx_packet_data -> tx_packet_data 67 then 2B.
//  3 Push 64 bytes (DEPTH=64) -> buffer_full=1. 65th byte dropped; occupancy stays 64;
//    overflow_err=1 with DATA_BUFFER_ERR_EN. Drain 64 -> original order, ptr wrap verified.
//  4 Occupancy 1, get_rx_data data_size=1 -> rx_data unchanged, occupancy 1, underflow_err=1 (if EN).
//  5 Occupancy 3, byte push + 2-byte get_rx_data in same cycle -> occupancy 2, rx_data holds the oldest 2 bytes.
//  6 Occupancy 5, assert clear -> occupancy 0 next cycle. Assert rst mid-burst -> outputs 0 immediately, no stray write.

Source files
------------

// File: rtl/param_data_buffer_if.sv
// param_data_buffer_if
//   Bundles the request, data and status signals of param_data_buffer.
//   master: the USB/AHB side that issues pushes/pops and observes status.
//   slave : the buffer itself.
//   Signals:
//     clear                 flush request
//     store_rx_packet_data  push one byte from rx_packet_data
//     get_rx_data           pop data_size+1 bytes onto rx_data
//     data_size             transfer length minus 1 (shared by word push/pop)
//     store_tx_data         push data_size+1 bytes of tx_data
//     get_tx_packet_data    pop one byte onto tx_packet_data
//     buffer_occupancy/full/empty, rx_data, tx_packet_data  buffer outputs
//   Optional (DATA_BUFFER_ERR_EN): overflow_err, underflow_err sticky flags.
interface param_data_buffer_if #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BUS_BYTES = 4
);
  localparam int unsigned SIZE_W = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1;
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
  localparam int unsigned DATA_W = 8 * BUS_BYTES;

  logic              clear;
  logic              store_rx_packet_data;
  logic [7:0]        rx_packet_data;
  logic              get_rx_data;
  logic [SIZE_W-1:0] data_size;
  logic [DATA_W-1:0] tx_data;
  logic              store_tx_data;
  logic              get_tx_packet_data;
  logic [OCC_W-1:0]  buffer_occupancy;
  logic              buffer_full;
  logic              buffer_empty;
  logic [DATA_W-1:0] rx_data;
  logic [7:0]        tx_packet_data;
`ifdef DATA_BUFFER_ERR_EN
  logic              overflow_err;
  logic              underflow_err;
`endif

  modport master (
    output clear, store_rx_packet_data, rx_packet_data, get_rx_data,
    output data_size, tx_data, store_tx_data, get_tx_packet_data,
    input  buffer_occupancy, buffer_full, buffer_empty, rx_data,
    input  tx_packet_data
`ifdef DATA_BUFFER_ERR_EN
    , input overflow_err, input underflow_err
`endif
  );

  modport slave (
    input  clear, store_rx_packet_data, rx_packet_data, get_rx_data,
    input  data_size, tx_data, store_tx_data, get_tx_packet_data,
    output buffer_occupancy, buffer_full, buffer_empty, rx_data,
    output tx_packet_data
`ifdef DATA_BUFFER_ERR_EN
    , output overflow_err, output underflow_err
`endif
  );
endinterface

// File: rtl/param_data_buffer.sv
// param_data_buffer
//   Circular byte FIFO between the byte-wide USB packet side and the
//   word-wide AHB-Lite slave. Little-endian: lane 0 is first in/out.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  param_data_buffer_if.slave (requests, data, status)
//   Write arbitration: store_tx_data beats store_rx_packet_data.
//   Read arbitration : get_rx_data beats get_tx_packet_data.
//   A transfer of n bytes is all-or-nothing against pre-edge occupancy.
//   Optional macro DATA_BUFFER_ERR_EN adds sticky overflow_err/underflow_err.
module param_data_buffer #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BUS_BYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  param_data_buffer_if.slave  bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
  localparam int unsigned DATA_W = 8 * BUS_BYTES;

  logic [7:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;

  logic [OCC_W-1:0]  xfer_len;
  logic [OCC_W-1:0]  free_bytes;
  logic [OCC_W-1:0]  n_wr_req;
  logic [OCC_W-1:0]  n_rd_req;
  logic [OCC_W-1:0]  n_wr;
  logic [OCC_W-1:0]  n_rd;
  logic              wr_tx, wr_rx, rd_rx, rd_tx;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    // Word length is capped at the bus width so no lane outside tx_data/rx_data is touched.
    xfer_len = OCC_W'(bus.data_size) + OCC_W'(1);
    if (xfer_len > OCC_W'(BUS_BYTES))
      xfer_len = OCC_W'(BUS_BYTES);

    free_bytes = OCC_W'(DEPTH) - occ;

    wr_tx = bus.store_tx_data;
    wr_rx = bus.store_rx_packet_data & ~bus.store_tx_data;
    rd_rx = bus.get_rx_data;
    rd_tx = bus.get_tx_packet_data & ~bus.get_rx_data;

    n_wr_req = wr_tx ? xfer_len : (wr_rx ? OCC_W'(1) : '0);
    n_rd_req = rd_rx ? xfer_len : (rd_tx ? OCC_W'(1) : '0);

    wr_ok = (wr_tx | wr_rx) && (free_bytes >= n_wr_req);
    rd_ok = (rd_rx | rd_tx) && (occ >= n_rd_req);

    n_wr = wr_ok ? n_wr_req : '0;
    n_rd = rd_ok ? n_rd_req : '0;

    wr_word = wr_tx ? bus.tx_data : DATA_W'(bus.rx_packet_data);

    rd_word = '0;
    for (int unsigned i = 0; i < BUS_BYTES; i++) begin
      if (OCC_W'(i) < n_rd)
        rd_word[8*i +: 8] = mem[rd_ptr + PTR_W'(i)];
    end
  end

  // Storage is deliberately not reset; writes are gated by rst/clear so
  // no byte lands on an edge where either is asserted.
  always_ff @(posedge clk) begin
    if (!rst && !bus.clear && wr_ok) begin
      for (int unsigned i = 0; i < BUS_BYTES; i++) begin
        if (OCC_W'(i) < n_wr)
          mem[wr_ptr + PTR_W'(i)] <= wr_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      occ                <= '0;
      bus.rx_data        <= '0;
      bus.tx_packet_data <= '0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_wr[PTR_W-1:0];
      rd_ptr <= rd_ptr + n_rd[PTR_W-1:0];
      occ    <= occ + n_wr - n_rd;
      if (rd_ok && rd_rx)
        bus.rx_data <= rd_word;
      if (rd_ok && rd_tx)
        bus.tx_packet_data <= rd_word[7:0];
    end
  end

  assign bus.buffer_occupancy = occ;
  assign bus.buffer_full      = (occ == OCC_W'(DEPTH));
  assign bus.buffer_empty     = (occ == '0);

`ifdef DATA_BUFFER_ERR_EN
  logic wr_lost;
  logic rd_lost;

  // A byte push that loses arbitration to a word push counts as a dropped write.
  assign wr_lost = ((wr_tx | wr_rx) && !wr_ok) ||
                   (bus.store_tx_data && bus.store_rx_packet_data);
  assign rd_lost = (rd_rx | rd_tx) && !rd_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.overflow_err  <= 1'b0;
      bus.underflow_err <= 1'b0;
    end else if (bus.clear) begin
      bus.overflow_err  <= 1'b0;
      bus.underflow_err <= 1'b0;
    end else begin
      if (wr_lost) bus.overflow_err  <= 1'b1;
      if (rd_lost) bus.underflow_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_param_data_buffer.sv
// tb_param_data_buffer
//   Directed bench for param_data_buffer (DEPTH=64, BUS_BYTES=4).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_param_data_buffer;
  logic tb_clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  param_data_buffer_if #(.DEPTH(64), .BUS_BYTES(4)) bus ();

  param_data_buffer #(.DEPTH(64), .BUS_BYTES(4)) dut (
    .clk (tb_clk),
    .rst (rst),
    .bus (bus)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clear                = 1'b0;
    bus.store_rx_packet_data = 1'b0;
    bus.rx_packet_data       = 8'h00;
    bus.get_rx_data          = 1'b0;
    bus.data_size            = 2'd0;
    bus.tx_data              = 32'h0;
    bus.store_tx_data        = 1'b0;
    bus.get_tx_packet_data   = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.store_rx_packet_data = 1'b1;
    bus.rx_packet_data       = b;
    step();
    bus.store_rx_packet_data = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (bus.buffer_occupancy !== 7'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", bus.buffer_occupancy); end
    n_cmp++; if (bus.buffer_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.buffer_empty); end
    n_cmp++; if (bus.buffer_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.buffer_full); end
    n_cmp++; if (bus.rx_data !== 32'h0) begin n_err++; $display("FAIL reset_rx_data: got %h want 0", bus.rx_data); end
    n_cmp++; if (bus.tx_packet_data !== 8'h0) begin n_err++; $display("FAIL reset_tx_byte: got %h want 0", bus.tx_packet_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_rx_word();
    push_byte(8'hFF);
    push_byte(8'hC9);
    push_byte(8'h9A);
    push_byte(8'h3B);
    n_cmp++; if (bus.buffer_occupancy !== 7'd4) begin n_err++; $display("FAIL rxw_occ4: got %0d want 4", bus.buffer_occupancy); end
    bus.get_rx_data = 1'b1;
    bus.data_size   = 2'd3;
    step();
    bus.get_rx_data = 1'b0;
    bus.data_size   = 2'd0;
    n_cmp++; if (bus.rx_data !== 32'h3B9AC9FF) begin n_err++; $display("FAIL rxw_data: got %h want 3b9ac9ff", bus.rx_data); end
    n_cmp++; if (bus.buffer_occupancy !== 7'd0) begin n_err++; $display("FAIL rxw_occ0: got %0d want 0", bus.buffer_occupancy); end
    n_cmp++; if (bus.buffer_empty !== 1'b1) begin n_err++; $display("FAIL rxw_empty: got %b want 1", bus.buffer_empty); end
  endtask

  task automatic test_tx_bytes();
    bus.store_tx_data = 1'b1;
    bus.tx_data       = 32'h00002B67;
    bus.data_size     = 2'd1;
    step();
    bus.store_tx_data = 1'b0;
    bus.data_size     = 2'd0;
    n_cmp++; if (bus.buffer_occupancy !== 7'd2) begin n_err++; $display("FAIL txb_occ2: got %0d want 2", bus.buffer_occupancy); end
    bus.get_tx_packet_data = 1'b1;
    step();
    n_cmp++; if (bus.tx_packet_data !== 8'h67) begin n_err++; $display("FAIL txb_first: got %h want 67", bus.tx_packet_data); end
    n_cmp++; if (bus.buffer_occupancy !== 7'd1) begin n_err++; $display("FAIL txb_occ1: got %0d want 1", bus.buffer_occupancy); end
    step();
    bus.get_tx_packet_data = 1'b0;
    n_cmp++; if (bus.tx_packet_data !== 8'h2B) begin n_err++; $display("FAIL txb_second: got %h want 2b", bus.tx_packet_data); end
    n_cmp++; if (bus.buffer_occupancy !== 7'd0) begin n_err++; $display("FAIL txb_occ0: got %0d want 0", bus.buffer_occupancy); end
  endtask

  // Pointers start at 6 here, so filling and draining 64 bytes crosses the wrap.
  task automatic test_full_wrap();
    logic [7:0] exp_b;
    bus.store_rx_packet_data = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.rx_packet_data = 8'(i * 7 + 5);
      step();
    end
    bus.store_rx_packet_data = 1'b0;
    n_cmp++; if (bus.buffer_full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b want 1", bus.buffer_full); end
    n_cmp++; if (bus.buffer_occupancy !== 7'd64) begin n_err++; $display("FAIL full_occ: got %0d want 64", bus.buffer_occupancy); end
`ifdef DATA_BUFFER_ERR_EN
    n_cmp++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL ovf_before: got %b want 0", bus.overflow_err); end
`endif
    push_byte(8'hEE);
    n_cmp++; if (bus.buffer_occupancy !== 7'd64) begin n_err++; $display("FAIL full_drop_occ: got %0d want 64", bus.buffer_occupancy); end
`ifdef DATA_BUFFER_ERR_EN
    n_cmp++; if (bus.overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_after: got %b want 1", bus.overflow_err); end
`endif
    bus.get_tx_packet_data = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      exp_b = 8'(i * 7 + 5);
      n_cmp++; if (bus.tx_packet_data !== exp_b) begin n_err++; $display("FAIL drain_byte%0d: got %h want %h", i, bus.tx_packet_data, exp_b); end
    end
    bus.get_tx_packet_data = 1'b0;
    n_cmp++; if (bus.buffer_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", bus.buffer_empty); end
  endtask

  task automatic test_underflow();
    push_byte(8'h55);
    bus.get_rx_data = 1'b1;
    bus.data_size   = 2'd1;
    step();
    bus.get_rx_data = 1'b0;
    bus.data_size   = 2'd0;
    n_cmp++; if (bus.rx_data !== 32'h3B9AC9FF) begin n_err++; $display("FAIL unf_rx_hold: got %h want 3b9ac9ff", bus.rx_data); end
    n_cmp++; if (bus.buffer_occupancy !== 7'd1) begin n_err++; $display("FAIL unf_occ: got %0d want 1", bus.buffer_occupancy); end
`ifdef DATA_BUFFER_ERR_EN
    n_cmp++; if (bus.underflow_err !== 1'b1) begin n_err++; $display("FAIL unf_flag: got %b want 1", bus.underflow_err); end
`endif
    bus.get_tx_packet_data = 1'b1;
    step();
    bus.get_tx_packet_data = 1'b0;
    n_cmp++; if (bus.tx_packet_data !== 8'h55) begin n_err++; $display("FAIL unf_drain: got %h want 55", bus.tx_packet_data); end
  endtask

  task automatic test_simultaneous();
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    bus.store_rx_packet_data = 1'b1;
    bus.rx_packet_data       = 8'h44;
    bus.get_rx_data          = 1'b1;
    bus.data_size            = 2'd1;
    step();
    bus.store_rx_packet_data = 1'b0;
    n_cmp++; if (bus.buffer_occupancy !== 7'd2) begin n_err++; $display("FAIL sim_occ: got %0d want 2", bus.buffer_occupancy); end
    n_cmp++; if (bus.rx_data !== 32'h00002211) begin n_err++; $display("FAIL sim_rx: got %h want 00002211", bus.rx_data); end
    step();
    bus.get_rx_data = 1'b0;
    bus.data_size   = 2'd0;
    n_cmp++; if (bus.rx_data !== 32'h00004433) begin n_err++; $display("FAIL sim_rx2: got %h want 00004433", bus.rx_data); end
    n_cmp++; if (bus.buffer_occupancy !== 7'd0) begin n_err++; $display("FAIL sim_occ0: got %0d want 0", bus.buffer_occupancy); end
  endtask

  task automatic test_clear();
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    n_cmp++; if (bus.buffer_occupancy !== 7'd5) begin n_err++; $display("FAIL clr_occ5: got %0d want 5", bus.buffer_occupancy); end
    bus.clear                = 1'b1;
    bus.store_rx_packet_data = 1'b1;
    bus.rx_packet_data       = 8'h99;
    bus.get_tx_packet_data   = 1'b1;
    step();
    idle_inputs();
    n_cmp++; if (bus.buffer_occupancy !== 7'd0) begin n_err++; $display("FAIL clr_occ0: got %0d want 0", bus.buffer_occupancy); end
    n_cmp++; if (bus.buffer_empty !== 1'b1) begin n_err++; $display("FAIL clr_empty: got %b want 1", bus.buffer_empty); end
    n_cmp++; if (bus.tx_packet_data !== 8'h55) begin n_err++; $display("FAIL clr_tx_hold: got %h want 55", bus.tx_packet_data); end
    n_cmp++; if (bus.rx_data !== 32'h00004433) begin n_err++; $display("FAIL clr_rx_hold: got %h want 00004433", bus.rx_data); end
`ifdef DATA_BUFFER_ERR_EN
    n_cmp++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %b want 0", bus.overflow_err); end
    n_cmp++; if (bus.underflow_err !== 1'b0) begin n_err++; $display("FAIL clr_unf: got %b want 0", bus.underflow_err); end
`endif
    push_byte(8'hA5);
    bus.get_tx_packet_data = 1'b1;
    step();
    bus.get_tx_packet_data = 1'b0;
    n_cmp++; if (bus.tx_packet_data !== 8'hA5) begin n_err++; $display("FAIL clr_restart: got %h want a5", bus.tx_packet_data); end
  endtask

  task automatic test_reset_mid();
    bus.store_rx_packet_data = 1'b1;
    bus.rx_packet_data       = 8'h77;
    step();
    step();
    n_cmp++; if (bus.buffer_occupancy !== 7'd2) begin n_err++; $display("FAIL rstm_occ2: got %0d want 2", bus.buffer_occupancy); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.buffer_occupancy !== 7'd0) begin n_err++; $display("FAIL rstm_occ_async: got %0d want 0", bus.buffer_occupancy); end
    n_cmp++; if (bus.rx_data !== 32'h0) begin n_err++; $display("FAIL rstm_rx: got %h want 0", bus.rx_data); end
    n_cmp++; if (bus.tx_packet_data !== 8'h0) begin n_err++; $display("FAIL rstm_tx: got %h want 0", bus.tx_packet_data); end
    step();
    n_cmp++; if (bus.buffer_occupancy !== 7'd0) begin n_err++; $display("FAIL rstm_occ_edge: got %0d want 0", bus.buffer_occupancy); end
    rst = 1'b0;
    bus.store_rx_packet_data = 1'b0;
    step();
    n_cmp++; if (bus.buffer_empty !== 1'b1) begin n_err++; $display("FAIL rstm_empty: got %b want 1", bus.buffer_empty); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_rx_word();
    test_tx_bytes();
    test_full_wrap();
    test_underflow();
    test_simultaneous();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
